// File: rtl/conv_dot_engine.sv
// Time-multiplexed 1-D convolution engine: snapshots X/F on start, then emits
// y[j] = sum_i x[j+i]*f[i] for every valid j on a valid/ready stream.
module conv_dot_engine #(
    parameter int WIDTH    = 16,
    parameter int XSIZE    = 8,
    parameter int FSIZE    = 4,
    parameter int LOGFSIZE = 2,
    parameter int OWIDTH   = 2*WIDTH+LOGFSIZE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic signed [WIDTH-1:0]  x_vec [XSIZE],
    input  logic signed [WIDTH-1:0]  f_vec [FSIZE],
    output logic                     busy,
    output logic signed [OWIDTH-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     done
);
    localparam int XW = (XSIZE > 1) ? $clog2(XSIZE) : 1;
    localparam int PW = 2*WIDTH;
    localparam logic [XW-1:0]       J_LAST = XW'(XSIZE-FSIZE);
    localparam logic [LOGFSIZE-1:0] I_LAST = LOGFSIZE'(FSIZE-1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_next;

    logic signed [WIDTH-1:0]  x_snap [XSIZE];
    logic signed [WIDTH-1:0]  f_snap [FSIZE];
    logic [XW-1:0]            j;
    logic [LOGFSIZE-1:0]      i;
    logic [XW-1:0]            x_idx;
    logic                     issuing;
    logic                     prod_valid;
    logic                     prod_first;
    logic                     prod_last;
    logic signed [PW-1:0]     prod;
    logic signed [OWIDTH-1:0] prod_ext;
    logic signed [OWIDTH-1:0] acc;
    logic signed [OWIDTH-1:0] acc_next;
    logic                     last_result;

    assign last_result = (j == J_LAST);
    assign x_idx       = j + XW'(i);
    assign prod_ext    = {{(OWIDTH-PW){prod[PW-1]}}, prod};
    // First tap of each output loads instead of adding, so no clear cycle is needed.
    assign acc_next    = prod_first ? prod_ext : acc + prod_ext;
    assign busy        = (state != IDLE);
    assign m_valid     = (state == OUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (prod_valid && prod_last) state_next = OUT;
            OUT:     if (m_ready) state_next = last_result ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < XSIZE; k++) x_snap[k] <= '0;
            for (int unsigned k = 0; k < FSIZE; k++) f_snap[k] <= '0;
            j          <= '0;
            i          <= '0;
            issuing    <= 1'b0;
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
            prod       <= '0;
            acc        <= '0;
            m_data     <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            prod_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Stored in load order: x_snap[k] is sample k.
                        for (int unsigned k = 0; k < XSIZE; k++) x_snap[k] <= x_vec[XSIZE-1-k];
                        for (int unsigned k = 0; k < FSIZE; k++) f_snap[k] <= f_vec[FSIZE-1-k];
                        j       <= '0;
                        i       <= '0;
                        issuing <= 1'b1;
                    end
                end
                MAC: begin
                    if (issuing) begin
                        prod       <= PW'(x_snap[x_idx]) * PW'(f_snap[i]);
                        prod_first <= (i == '0);
                        prod_last  <= (i == I_LAST);
                        prod_valid <= 1'b1;
                        if (i == I_LAST) begin
                            issuing <= 1'b0;
                        end else begin
                            i <= i + LOGFSIZE'(1);
                        end
                    end
                    if (prod_valid) begin
                        acc <= acc_next;
                        if (prod_last) m_data <= acc_next;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        if (last_result) begin
                            done <= 1'b1;
                        end else begin
                            j       <= j + XW'(1);
                            i       <= '0;
                            issuing <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_dot_engine.sv
// Self-checking bench for conv_dot_engine: directed and random runs against
// a plain-arithmetic convolution model with latency, backpressure and reset checks.
module tb_conv_dot_engine;
    localparam int WIDTH    = 16;
    localparam int XSIZE    = 8;
    localparam int FSIZE    = 4;
    localparam int LOGFSIZE = 2;
    localparam int OWIDTH   = 2*WIDTH+LOGFSIZE;
    localparam int NRES     = XSIZE-FSIZE+1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic m_ready = 1'b0;
    logic signed [WIDTH-1:0]  x_vec [XSIZE];
    logic signed [WIDTH-1:0]  f_vec [FSIZE];
    logic                     busy;
    logic                     m_valid;
    logic                     done;
    logic signed [OWIDTH-1:0] m_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ref_cyc = 0;
    longint xk [XSIZE];
    longint fk [FSIZE];
    longint exp_y [NRES];

    conv_dot_engine #(
        .WIDTH(WIDTH), .XSIZE(XSIZE), .FSIZE(FSIZE), .LOGFSIZE(LOGFSIZE), .OWIDTH(OWIDTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x_vec(x_vec), .f_vec(f_vec),
        .busy(busy), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_random_vectors();
        logic signed [WIDTH-1:0] r;
        for (int k = 0; k < XSIZE; k++) begin r = WIDTH'($urandom); xk[k] = r; end
        for (int k = 0; k < FSIZE; k++) begin r = WIDTH'($urandom); fk[k] = r; end
    endtask

    // Drives the vectors and a one-cycle start; exp_y gets the model's results.
    task automatic start_run();
        logic signed [WIDTH-1:0] v;
        for (int k = 0; k < XSIZE; k++) begin v = WIDTH'(xk[k]); x_vec[XSIZE-1-k] = v; end
        for (int k = 0; k < FSIZE; k++) begin v = WIDTH'(fk[k]); f_vec[FSIZE-1-k] = v; end
        for (int jj = 0; jj < NRES; jj++) begin
            exp_y[jj] = 0;
            for (int ii = 0; ii < FSIZE; ii++) exp_y[jj] += xk[jj+ii] * fk[ii];
        end
        start = 1'b1;
        ref_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
    endtask

    task automatic drain(input int nres, input int max_stall, input int glitch_at);
        int n;
        int stall;
        for (int jj = 0; jj < nres; jj++) begin
            n = 0;
            while (!m_valid && n < 40) begin @(negedge clk); n++; end
            check("valid_seen", m_valid, 1);
            check("latency", cyc - ref_cyc, FSIZE + 2);
            check("data", m_data, exp_y[jj]);
            if (jj == glitch_at) stall = 5;
            else stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            for (int s = 0; s < stall; s++) begin
                m_ready = 1'b0;
                if (jj == glitch_at) begin
                    for (int k = 0; k < XSIZE; k++) x_vec[k] = WIDTH'($urandom);
                    for (int k = 0; k < FSIZE; k++) f_vec[k] = WIDTH'($urandom);
                    start = (s % 2 == 0);
                end
                @(negedge clk);
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, exp_y[jj]);
            end
            start = 1'b0;
            m_ready = 1'b1;
            ref_cyc = cyc;
            @(negedge clk);
            m_ready = 1'b0;
            if (jj < NRES - 1) begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
                check("valid_drop_mid", m_valid, 0);
            end else begin
                check("done_pulse", done, 1);
                check("busy_drop", busy, 0);
                check("valid_drop_end", m_valid, 0);
            end
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", m_valid, 0);
    endtask

    initial begin
        for (int k = 0; k < XSIZE; k++) x_vec[k] = '0;
        for (int k = 0; k < FSIZE; k++) f_vec[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic ramp with unit taps
        for (int k = 0; k < XSIZE; k++) xk[k] = k + 1;
        for (int k = 0; k < FSIZE; k++) fk[k] = 1;
        start_run();
        exp_y = '{10, 14, 18, 22, 26};
        drain(NRES, 0, -1);
        idle_check();

        // Most-negative operands: 4 * 2^30 must not wrap
        for (int k = 0; k < XSIZE; k++) xk[k] = -32768;
        for (int k = 0; k < FSIZE; k++) fk[k] = -32768;
        start_run();
        exp_y = '{64'sd4294967296, 64'sd4294967296, 64'sd4294967296, 64'sd4294967296, 64'sd4294967296};
        drain(NRES, 0, -1);
        idle_check();

        // Alternating taps
        for (int k = 0; k < XSIZE; k++) xk[k] = k + 1;
        fk = '{1, -1, 1, -1};
        start_run();
        exp_y = '{-2, -2, -2, -2, -2};
        drain(NRES, 0, -1);
        idle_check();

        // Backpressure on y[2] with input churn and ignored start pulses
        set_random_vectors();
        start_run();
        drain(NRES, 0, 2);
        idle_check();

        // Reset during MAC of y[1]
        for (int k = 0; k < XSIZE; k++) xk[k] = k + 1;
        for (int k = 0; k < FSIZE; k++) fk[k] = 1;
        start_run();
        drain(1, 0, -1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_valid", m_valid, 0);
        end
        for (int k = 0; k < XSIZE; k++) xk[k] = k + 2;
        fk = '{1, 0, 0, 0};
        start_run();
        exp_y = '{2, 3, 4, 5, 6};
        drain(NRES, 0, -1);

        // Back-to-back: start in the done cycle, then random runs with random stalls
        for (int r = 0; r < 4; r++) begin
            set_random_vectors();
            start_run();
            drain(NRES, 3, -1);
        end
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_dot_engine.md
Name: conv_dot_engine

Overview:
- Downstream consumer of the X and F parallel-output shift memories.
- On `start`, snapshots the full X vector and F vector, then computes every valid 1-D convolution output y[j] = sum over i of x[j+i]*f[i], one time-multiplexed signed multiplier at a time.
- Results leave in order on a valid/ready stream toward the output writer.
- Snapshotting lets the upstream memories reload the next vectors while this block computes.

Parameters:
- WIDTH, 16, bit width of each signed X and F element.
- XSIZE, 8, number of X elements presented in parallel.
- FSIZE, 4, number of F taps presented in parallel (FSIZE <= XSIZE).
- LOGFSIZE, 2, ceil(log2(FSIZE)), minimum 1.
- OWIDTH, 2*WIDTH+LOGFSIZE (34), width of each signed result.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a convolution; x_vec/f_vec must be valid in the same cycle
- x_vec  input  WIDTH x XSIZE (signed, unpacked)  X memory contents; element k = x_vec[XSIZE-1-k] (k=0 is the first sample loaded)
- f_vec  input  WIDTH x FSIZE (signed, unpacked)  F memory contents; tap i = f_vec[FSIZE-1-i]
- busy  output  1  high from start acceptance until the last result is accepted
- m_data  output  OWIDTH (signed)  current result y[j]
- m_valid  output  1  m_data holds a valid result
- m_ready  input  1  downstream accepts m_data when high together with m_valid
- done  output  1  one-cycle pulse after the final result is accepted

Behaviour:
- Reset (async, reset_n=0):
  - busy=0, m_valid=0, m_data=0, done=0.
  - State IDLE; counters, accumulator, product register and snapshot registers cleared.
  - Reset asserted mid-operation aborts at once; no partial result is emitted after release.
- States: IDLE, MAC, OUT.
- IDLE:
  - start=1 at an edge latches x_vec and f_vec into internal copies, sets j=0, i=0, busy=1, and moves to MAC.
  - start is ignored in all other states.
- MAC:
  - Each cycle, issues x[j+i]*f[i] into a registered full-precision (2*WIDTH) product stage and increments i.
  - Next cycle the accumulator loads the product when i was 0 (no separate clear), otherwise adds it.
  - Accumulate is sign-extended to OWIDTH; cannot overflow.
  - After the accumulate for i=FSIZE-1: state becomes OUT, m_valid=1, m_data=accumulator.
- Latency:
  - start sampled at the edge ending cycle t gives m_valid=1 in cycle t+FSIZE+2.
  - The same holds from each accept edge to the next result.
- OUT:
  - m_valid and m_data hold stable while m_ready=0, for any number of cycles.
  - On m_valid&&m_ready with j < XSIZE-FSIZE: j++, i=0, m_valid=0 next cycle, re-enter MAC.
  - On m_valid&&m_ready with j = XSIZE-FSIZE: m_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
- Result count: XSIZE-FSIZE+1 per start. If XSIZE=FSIZE, exactly one result.
- start in the same cycle as done: accepted (state is IDLE). busy rises again next cycle; done still pulses.
- m_ready while m_valid=0: no effect.
- Snapshot registers change only on accepted start, so changes on x_vec/f_vec during MAC/OUT do not affect results.

Test Plan:
- Basic: x=1..8 (k=0..7), f=1,1,1,1, m_ready=1 -> m_data sequence 10,14,18,22,26; done pulses once the cycle after the 5th accept; busy drops the same cycle.
- Latency: start in cycle 0 with m_ready=1 -> first m_valid in cycle 6; each later result 6 cycles after the previous accept cycle.
- Sign/extremes: all x=-32768, all f=-32768 -> every y=4294967296 (2^32), no wrap in 34 bits. f=1,-1,1,-1 with x=1..8 -> all five y=-2.
- Backpressure + isolation: hold m_ready=0 for 5 cycles on y[2]; change x_vec/f_vec and pulse start meanwhile -> m_data steady, m_valid steady, start ignored, results unchanged.
- Reset mid-op: assert reset_n=0 during MAC of y[1] -> outputs zero immediately. Release, then new start with x=2..9, f=1,0,0,0 -> outputs 2,3,4,5,6 with no stale data.
- Back-to-back: start asserted in the done cycle -> second run accepted, busy=1 next cycle, correct results for the new vectors.
